// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DE = 1'b1
   } req_id_t;

   function automatic req_id_t other_id(input req_id_t id);
      return (id == REQ_IF) ? REQ_DE : REQ_IF;
   endfunction

endpackage

// File: rtl/mem_port_arb_pick.sv
// Combinational winner choice between fetch and data requesters.
// MEM_ARB_RR_EN: ties go to the requester named by prio, otherwise data always wins.
module arb_pick
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  req_id_t prio,
`endif
   input  logic    if_req,
   input  logic    de_req,
   output logic    any_c,
   output req_id_t win_c
);

   always_comb begin
      any_c = if_req | de_req;
      win_c = REQ_DE;
      if (if_req && !de_req) begin
         win_c = REQ_IF;
      end
`ifdef MEM_ARB_RR_EN
      else if (if_req && de_req) begin
         win_c = prio;
      end
`endif
   end

endmodule

// File: rtl/mem_port_arb.sv
// Single-port synchronous memory arbiter: fetch and data requesters, IDLE/ACCESS/RESP FSM.
// MEM_ARB_RR_EN selects round-robin tie resolution instead of fixed data priority.
module mem_port_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   input  logic              de_req,
   input  logic              de_we,
   input  logic [ADDR_W-1:0] de_addr,
   input  logic [DATA_W-1:0] de_wdata,
   output logic              de_gnt,
   output logic              de_valid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            state, state_nxt;
   req_id_t           win_q, win_nxt;
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              mem_we_nxt;
   logic              if_gnt_nxt, de_gnt_nxt;
   logic              if_valid_nxt, de_valid_nxt;
   logic              busy_nxt;
   logic              arb_en;
   logic              any_c;
   req_id_t           win_c;

`ifdef MEM_ARB_RR_EN
   req_id_t           ptr_q, ptr_nxt;
`endif

   arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
      .prio   (ptr_q),
`endif
      .if_req (if_req),
      .de_req (de_req),
      .any_c  (any_c),
      .win_c  (win_c)
   );

   // Next state and next registered outputs; mem_addr/mem_wdata double as the latched operands
   always_comb begin
      state_nxt    = state;
      win_nxt      = win_q;
      we_nxt       = we_q;
      addr_nxt     = mem_addr;
      wdata_nxt    = mem_wdata;
      rdata_nxt    = rdata;
      mem_we_nxt   = 1'b0;
      if_gnt_nxt   = 1'b0;
      de_gnt_nxt   = 1'b0;
      if_valid_nxt = 1'b0;
      de_valid_nxt = 1'b0;
      arb_en       = 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr_nxt      = ptr_q;
`endif

      case (state)
         ST_IDLE: begin
            arb_en = 1'b1;
         end
         ST_ACCESS: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            arb_en = 1'b1;
            if (!we_q) begin
               rdata_nxt = mem_rdata;
            end
            if (win_q == REQ_DE) begin
               de_valid_nxt = 1'b1;
            end else begin
               if_valid_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Arbitration at the IDLE edge or the RESP-end edge
      if (arb_en) begin
         state_nxt = ST_IDLE;
         if (any_c) begin
            state_nxt = ST_ACCESS;
            win_nxt   = win_c;
`ifdef MEM_ARB_RR_EN
            ptr_nxt   = other_id(win_c);
`endif
            if (win_c == REQ_DE) begin
               addr_nxt   = de_addr;
               wdata_nxt  = de_wdata;
               we_nxt     = de_we;
               mem_we_nxt = de_we;
               de_gnt_nxt = 1'b1;
            end else begin
               addr_nxt   = if_addr;
               wdata_nxt  = '0;
               we_nxt     = 1'b0;
               if_gnt_nxt = 1'b1;
            end
         end
      end

      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         win_q     <= REQ_DE;
         we_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         rdata     <= '0;
         if_gnt    <= 1'b0;
         de_gnt    <= 1'b0;
         if_valid  <= 1'b0;
         de_valid  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         win_q     <= win_nxt;
         we_q      <= we_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         mem_we    <= mem_we_nxt;
         rdata     <= rdata_nxt;
         if_gnt    <= if_gnt_nxt;
         de_gnt    <= de_gnt_nxt;
         if_valid  <= if_valid_nxt;
         de_valid  <= de_valid_nxt;
         busy      <= busy_nxt;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Tie pointer names the requester preferred at the next collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= REQ_DE;
      end else begin
         ptr_q <= ptr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed vector table, hand sequences and a random run
// against a transaction-level reference model. Honours MEM_ARB_RR_EN like the design.
module tb_mem_port_arb;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_valid;
   logic          de_req;
   logic          de_we;
   logic [AW-1:0] de_addr;
   logic [DW-1:0] de_wdata;
   logic          de_gnt;
   logic          de_valid;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   mem_port_arb dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_valid  (if_valid),
      .de_req    (de_req),
      .de_we     (de_we),
      .de_addr   (de_addr),
      .de_wdata  (de_wdata),
      .de_gnt    (de_gnt),
      .de_valid  (de_valid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [DW-1:0] mem     [256];
   logic [DW-1:0] ref_mem [256];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic          ir;
      logic          dr;
      logic          dwe;
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      logic [DW-1:0] dw;
      logic          exp_de;
      logic [DW-1:0] exp_rd;
   } vec_t;

   typedef struct {
      int            vc;
      bit            de;
      bit            rd;
      logic [DW-1:0] d;
   } vrec_t;

   vec_t  tv [7];
   vrec_t vq [$];

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic chk16(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // One clock; the memory model samples the port mid-cycle and updates just after the edge
   task automatic step();
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      @(negedge clk);
      w = mem_we;
      a = mem_addr;
      d = mem_wdata;
      @(posedge clk);
      #1;
      mem_rdata = mem[a];
      if (w) mem[a] = d;
      cyc++;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      if_req = 1'b0;
      de_req = 1'b0;
      de_we  = 1'b0;
      #1;
      chk1("rst_if_gnt", if_gnt, 1'b0);
      chk1("rst_de_gnt", de_gnt, 1'b0);
      chk1("rst_if_valid", if_valid, 1'b0);
      chk1("rst_de_valid", de_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk16("rst_mem_addr", 16'(mem_addr), 16'h0);
      chk16("rst_mem_wdata", mem_wdata, 16'h0);
      chk16("rst_rdata", rdata, 16'h0);
      step();
      step();
      rst = 1'b0;
   endtask

   // Reference model state (transaction level)
   int            next_arb;
   int            g_edge;
   bit            g_de;
   bit            g_we;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic [DW-1:0] exp_rd;
   bit            if_pend;
   bit            de_pend;
`ifdef MEM_ARB_RR_EN
   bit            prefer_de;
`endif

   task automatic model_reset();
      next_arb = 0;
      g_edge   = -100;
      g_de     = 1'b0;
      g_we     = 1'b0;
      g_addr   = '0;
      g_wdata  = '0;
      exp_rd   = '0;
      if_pend  = 1'b0;
      de_pend  = 1'b0;
      vq.delete();
`ifdef MEM_ARB_RR_EN
      prefer_de = 1'b1;
`endif
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
   endtask

   // Arbitration decision for the coming edge e, if the port is free there
   task automatic model_edge(input int e);
      bit    wde;
      vrec_t r;
      if (e >= next_arb) begin
         if (if_req || de_req) begin
`ifdef MEM_ARB_RR_EN
            wde = de_req && (!if_req || prefer_de);
            prefer_de = !wde;
`else
            wde = de_req;
`endif
            g_edge  = e;
            g_de    = wde;
            g_we    = wde && de_we;
            g_addr  = wde ? de_addr : if_addr;
            g_wdata = de_wdata;
            r.vc = e + 2;
            r.de = wde;
            r.rd = !g_we;
            r.d  = ref_mem[g_addr];
            if (g_we) ref_mem[g_addr] = g_wdata;
            vq.push_back(r);
            next_arb = e + 2;
         end else begin
            next_arb = e + 1;
         end
      end
   endtask

   task automatic model_check(input int e);
      logic  ev_if, ev_de;
      vrec_t r;
      ev_if = 1'b0;
      ev_de = 1'b0;
      chk1("rnd_if_gnt", if_gnt, (g_edge == e) && !g_de);
      chk1("rnd_de_gnt", de_gnt, (g_edge == e) && g_de);
      chk1("rnd_mem_we", mem_we, (g_edge == e) && g_we);
      chk1("rnd_busy", busy, (g_edge == e) || (g_edge == e - 1));
      if (g_edge == e) begin
         chk16("rnd_mem_addr", 16'(mem_addr), 16'(g_addr));
         if (g_we) chk16("rnd_mem_wdata", mem_wdata, g_wdata);
      end
      if (vq.size() > 0 && vq[0].vc == e) begin
         r = vq.pop_front();
         if (r.de) ev_de = 1'b1;
         else ev_if = 1'b1;
         if (r.rd) exp_rd = r.d;
      end
      chk1("rnd_if_valid", if_valid, ev_if);
      chk1("rnd_de_valid", de_valid, ev_de);
      chk16("rnd_rdata", rdata, exp_rd);
   endtask

   initial begin
      int ng;
      int nv;
      int ai;
      int lastv;
      logic [DW-1:0] seq43 [4];

      rst       = 1'b0;
      if_req    = 1'b0;
      if_addr   = '0;
      de_req    = 1'b0;
      de_we     = 1'b0;
      de_addr   = '0;
      de_wdata  = '0;
      mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      #1;
      do_reset();

      // Directed vectors, each from a fresh reset (tie pointer at data)
      mem[8'h05] = 16'h1234;
      mem[8'h33] = 16'hCAFE;
      mem[8'h7F] = 16'h0F0F;
      mem[8'hFF] = 16'hA5A5;
      mem[8'h00] = 16'h8001;
      tv[0] = '{1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0000, 1'b0, 16'h1234};
      tv[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 16'h0000, 1'b1, 16'hCAFE};
      tv[2] = '{1'b1, 1'b1, 1'b0, 8'h05, 8'hFF, 16'h0000, 1'b1, 16'hA5A5};
      tv[3] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h40, 16'h1357, 1'b1, 16'h0000};
      tv[4] = '{1'b1, 1'b1, 1'b1, 8'h7F, 8'hFF, 16'hFFFF, 1'b1, 16'h0000};
      tv[5] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 16'h0000, 1'b0, 16'hFFFF};
      tv[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 16'h8001};
      for (int v = 0; v < 7; v++) begin
         do_reset();
         if_req   = tv[v].ir;
         if_addr  = tv[v].ia;
         de_req   = tv[v].dr;
         de_we    = tv[v].dwe;
         de_addr  = tv[v].da;
         de_wdata = tv[v].dw;
         step();
         chk1("tv_if_gnt", if_gnt, !tv[v].exp_de);
         chk1("tv_de_gnt", de_gnt, tv[v].exp_de);
         chk1("tv_mem_we", mem_we, tv[v].exp_de && tv[v].dwe);
         chk16("tv_mem_addr", 16'(mem_addr), 16'(tv[v].exp_de ? tv[v].da : tv[v].ia));
         if_req = 1'b0;
         de_req = 1'b0;
         step();
         chk1("tv_resp_mem_we", mem_we, 1'b0);
         chk1("tv_resp_busy", busy, 1'b1);
         step();
         chk1("tv_if_valid", if_valid, !tv[v].exp_de);
         chk1("tv_de_valid", de_valid, tv[v].exp_de);
         chk16("tv_rdata", rdata, tv[v].exp_rd);
         chk1("tv_idle_busy", busy, 1'b0);
         if (tv[v].exp_de && tv[v].dwe) chk16("tv_mem_written", mem[tv[v].da], tv[v].dw);
      end

      // Collision: data write wins, fetch held and granted as data completes
      do_reset();
      mem[8'h00] = 16'h8001;
      mem[8'h10] = 16'h0000;
      if_req = 1'b1;  if_addr = 8'h00;
      de_req = 1'b1;  de_we = 1'b1;  de_addr = 8'h10;  de_wdata = 16'hBEEF;
      step();
      chk1("col_de_gnt", de_gnt, 1'b1);
      chk1("col_if_gnt0", if_gnt, 1'b0);
      chk1("col_mem_we", mem_we, 1'b1);
      chk16("col_mem_wdata", mem_wdata, 16'hBEEF);
      de_req = 1'b0;
      step();
      chk1("col_mem_we_resp", mem_we, 1'b0);
      chk1("col_if_gnt_early", if_gnt, 1'b0);
      step();
      chk1("col_de_valid", de_valid, 1'b1);
      chk1("col_if_gnt", if_gnt, 1'b1);
      chk16("col_mem10", mem[8'h10], 16'hBEEF);
      if_req = 1'b0;
      step();
      chk1("col_if_valid_early", if_valid, 1'b0);
      step();
      chk1("col_if_valid", if_valid, 1'b1);
      chk1("col_de_valid_once", de_valid, 1'b0);
      chk16("col_rdata", rdata, 16'h8001);

      // Reset in the ACCESS cycle of a write
      do_reset();
      mem[8'h20] = 16'h1111;
      de_req = 1'b1;  de_we = 1'b1;  de_addr = 8'h20;  de_wdata = 16'h5555;
      step();
      chk1("rw_mem_we_pre", mem_we, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("rw_mem_we", mem_we, 1'b0);
      chk1("rw_de_gnt", de_gnt, 1'b0);
      chk1("rw_busy", busy, 1'b0);
      chk16("rw_mem_addr", 16'(mem_addr), 16'h0);
      de_req = 1'b0;
      de_we  = 1'b0;
      step();
      step();
      rst = 1'b0;
      ng = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (de_valid) ng++;
      end
      chkn("rw_no_valid", ng, 0);
      chk16("rw_mem20", mem[8'h20], 16'h1111);

      // Both requesters held for eight grants
      do_reset();
      if_req = 1'b1;  if_addr = 8'h02;
      de_req = 1'b1;  de_we = 1'b0;  de_addr = 8'h01;
      ng = 0;
      for (int c = 0; c < 40 && ng < 8; c++) begin
         step();
         if (if_gnt || de_gnt) begin
            chk1("hold_both_gnt", if_gnt && de_gnt, 1'b0);
`ifdef MEM_ARB_RR_EN
            chk1("hold_grant_seq", de_gnt, (ng % 2) == 0);
`else
            chk1("hold_grant_seq", de_gnt, 1'b1);
`endif
            ng++;
         end
      end
      chkn("hold_grant_count", ng, 8);
      if_req = 1'b0;
      de_req = 1'b0;
      step();
      step();

      // Back-to-back fetches 0..3 with if_req held
      do_reset();
      seq43[0] = 16'h1111;  seq43[1] = 16'h2222;  seq43[2] = 16'h3333;  seq43[3] = 16'h4444;
      for (int i = 0; i < 4; i++) mem[i] = seq43[i];
      if_req  = 1'b1;
      if_addr = 8'h00;
      ai = 0;
      nv = 0;
      lastv = 0;
      for (int c = 0; c < 30 && nv < 4; c++) begin
         step();
         if (if_valid) begin
            chk16("b2b_rdata", rdata, seq43[nv]);
            if (nv > 0) chkn("b2b_spacing", cyc - lastv, 2);
            lastv = cyc;
            nv++;
         end
         if (if_gnt) begin
            ai++;
            if (ai == 4) if_req = 1'b0;
            else if_addr = 8'(ai);
         end
      end
      chkn("b2b_valid_count", nv, 4);

      // Random traffic against the transaction-level model
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      model_reset();
      for (int it = 0; it < 1500; it++) begin
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            if_addr = 8'($urandom_range(0, 15));
         end
         if (!de_pend && $urandom_range(0, 2) == 0) begin
            de_pend  = 1'b1;
            de_we    = 1'($urandom_range(0, 1));
            de_addr  = 8'($urandom_range(0, 15));
            de_wdata = 16'($urandom);
         end
         if_req = if_pend;
         de_req = de_pend;
         model_edge(cyc + 1);
         step();
         model_check(cyc);
         if (g_edge == cyc) begin
            if (g_de) de_pend = 1'b0;
            else if_pend = 1'b0;
         end
         if (it == 700 || it == 1101) begin
            do_reset();
            model_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
